// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues req/ack reads to
// instruction memory and delivers instruction + PC to decode. Handles
// decode stall (1-entry skid buffer), memory bus conflicts and jump
// redirects with flush of anything fetched on the wrong path.
module instruction_fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] nextPCIn,
    input  logic        jumpTaken,
    input  logic        stall,
    input  logic        memBusy,
    input  logic        memAck,
    input  logic [15:0] memData,
    output logic        memReq,
    output logic [15:0] memAddr,
    output logic [15:0] instructionOut,
    output logic [15:0] currentPCOut,
    output logic        valid
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_t;

    state_t      state_q;
    logic [15:0] pc_q, addr_q, instr_q, cur_pc_q, buf_q, buf_pc_q;
    logic        req_q, valid_q;
    logic        slot_free;
    logic [15:0] pc_inc_d;

    // Output slot can take a new word if empty or being consumed this cycle
    always_comb begin
        slot_free = !valid_q || !stall;
        pc_inc_d  = pc_q + 16'd2;
    end

    // Fetch FSM; every output is a register updated here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC;
            req_q    <= 1'b0;
            instr_q  <= NOP_INSTR;
            cur_pc_q <= RESET_PC;
            valid_q  <= 1'b0;
            buf_q    <= NOP_INSTR;
            buf_pc_q <= RESET_PC;
        end else if (jumpTaken) begin
            // Redirect wins over everything: flush output and buffer
            pc_q    <= nextPCIn;
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            if (req_q && !memAck) begin
                // Bus transaction cannot be aborted; wait it out and discard
                state_q <= DROP;
            end else begin
                state_q <= REQ;
                req_q   <= !memBusy;
                if (!memBusy) addr_q <= nextPCIn;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= REQ;
                    req_q   <= !memBusy;
                    if (!memBusy) addr_q <= pc_q;
                end
                REQ: begin
                    if (req_q && memAck) begin
                        pc_q <= pc_inc_d;
                        if (slot_free) begin
                            instr_q  <= memData;
                            cur_pc_q <= addr_q;
                            valid_q  <= 1'b1;
                            // Back-to-back request keeps 1 instr/cycle
                            req_q    <= !memBusy;
                            if (!memBusy) addr_q <= pc_inc_d;
                        end else begin
                            buf_q    <= memData;
                            buf_pc_q <= addr_q;
                            req_q    <= 1'b0;
                            state_q  <= HOLD;
                        end
                    end else begin
                        if (valid_q && !stall) begin
                            valid_q <= 1'b0;
                            instr_q <= NOP_INSTR;
                        end
                        if (!req_q && !memBusy) begin
                            req_q  <= 1'b1;
                            addr_q <= pc_q;
                        end
                    end
                end
                HOLD: begin
                    req_q <= 1'b0;
                    if (!stall) begin
                        instr_q  <= buf_q;
                        cur_pc_q <= buf_pc_q;
                        valid_q  <= 1'b1;
                        state_q  <= REQ;
                        req_q    <= !memBusy;
                        if (!memBusy) addr_q <= pc_q;
                    end
                end
                DROP: begin
                    if (valid_q && !stall) begin
                        valid_q <= 1'b0;
                        instr_q <= NOP_INSTR;
                    end
                    if (memAck) begin
                        // Stale wrong-path data is dropped; start the new path
                        state_q <= REQ;
                        req_q   <= !memBusy;
                        if (!memBusy) addr_q <= pc_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign memReq         = req_q;
    assign memAddr        = addr_q;
    assign instructionOut = instr_q;
    assign currentPCOut   = cur_pc_q;
    assign valid          = valid_q;

endmodule
